// File: rtl/avg_pkg.sv
// Shared types and defaults for the vector-generator frame scheduler.
package avg_pkg;
  localparam int AVG_COORD_W_DEF = 11;
  localparam int AVG_COLOR_W_DEF = 3;
  localparam int AVG_TIMEOUT_DEF = 100000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_KICK,
    S_RUN,
    S_SWAP
  } avg_sched_state_e;

  typedef struct packed {
    logic [AVG_COORD_W_DEF-1:0] startX;
    logic [AVG_COORD_W_DEF-1:0] startY;
    logic [AVG_COORD_W_DEF-1:0] endX;
    logic [AVG_COORD_W_DEF-1:0] endY;
    logic [AVG_COLOR_W_DEF-1:0] color;
  } avg_line_t;
endpackage

// File: rtl/avg_frame_sched_if.sv
// Signal bundle between the frame scheduler, avg_core, lineRegQueue and the drawer.
interface avg_frame_sched_if #(
  parameter int COORD_W = 11,
  parameter int COLOR_W = 3
);
  logic               vblank;
  logic               vg_halt;
  logic               vggo;
  logic               q_empty;
  logic [COORD_W-1:0] q_startX;
  logic [COORD_W-1:0] q_startY;
  logic [COORD_W-1:0] q_endX;
  logic [COORD_W-1:0] q_endY;
  logic [COLOR_W-1:0] q_color;
  logic               q_read;
  logic [COORD_W-1:0] ln_startX;
  logic [COORD_W-1:0] ln_startY;
  logic [COORD_W-1:0] ln_endX;
  logic [COORD_W-1:0] ln_endY;
  logic [COLOR_W-1:0] ln_color;
  logic               ln_valid;
  logic               ln_ready;
  logic               draw_busy;
  logic               frame_swap;
  logic               timeout;
  logic [7:0]         overrun_cnt;

  // Handshake: a line transfers on the edge where ln_valid & ln_ready; once
  // ln_valid rises the ln_* fields hold until that edge. The queue head is
  // valid while !q_empty and is consumed on the edge where q_read is high.
  modport master (
    input  vblank, vg_halt, q_empty, q_startX, q_startY, q_endX, q_endY, q_color,
    input  ln_ready, draw_busy,
    output vggo, q_read, ln_startX, ln_startY, ln_endX, ln_endY, ln_color,
    output ln_valid, frame_swap, timeout, overrun_cnt
  );

  modport slave (
    output vblank, vg_halt, q_empty, q_startX, q_startY, q_endX, q_endY, q_color,
    output ln_ready, draw_busy,
    input  vggo, q_read, ln_startX, ln_startY, ln_endX, ln_endY, ln_color,
    input  ln_valid, frame_swap, timeout, overrun_cnt
  );
endinterface

// File: rtl/avg_line_slot.sv
// One-entry output register holding the line currently offered to the drawer.
module avg_line_slot #(
  parameter int LINE_W = 47
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              i_load,
  input  logic [LINE_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [LINE_W-1:0] o_data,
  output logic              o_free
);
  logic              r_valid;
  logic [LINE_W-1:0] r_data;

  // A load is only issued when the slot is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_free  = ~r_valid | i_ready;
endmodule

// File: rtl/avg_frame_sched.sv
// Per-frame controller: kicks avg_core on vblank, drains queued lines to the
// drawer, and pulses frame_swap once core, queue and drawer are all quiet.
module avg_frame_sched
  import avg_pkg::*;
#(
  parameter int COORD_W = AVG_COORD_W_DEF,
  parameter int COLOR_W = AVG_COLOR_W_DEF,
  parameter int TIMEOUT = AVG_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  avg_frame_sched_if.master bus,
  output avg_sched_state_e o_dbg_state
);
  localparam int LINE_W = 4 * COORD_W + COLOR_W;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  avg_sched_state_e  r_state;
  avg_sched_state_e  w_next_state;
  logic              r_armed;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_overrun;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_vggo;
  logic              w_swap;
  logic              w_run;
  logic              w_q_read;
  logic              w_done;
  logic              w_tmo;
  logic              w_valid;
  logic              w_slot_free;
  logic [LINE_W-1:0] w_head;
  logic [LINE_W-1:0] w_line;

  assign w_head    = {bus.q_startX, bus.q_startY, bus.q_endX, bus.q_endY, bus.q_color};
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  // r_armed is registered, so a halt seen before the core has run this frame never ends it.
  assign w_done    = r_armed & bus.vg_halt & bus.q_empty & ~w_valid & ~bus.draw_busy;
  // RUN lasts at most TIMEOUT cycles: the TIMEOUT-th RUN cycle forces the exit.
  assign w_tmo     = (w_cnt_inc >= TIMEOUT_C);
  assign w_q_read  = w_run & ~bus.q_empty & w_slot_free;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_vggo       = 1'b0;
    w_swap       = 1'b0;
    w_run        = 1'b0;
    case (r_state)
      S_IDLE: if (bus.vblank) w_next_state = S_KICK;
      S_KICK: begin
        w_vggo       = 1'b1;
        w_next_state = S_RUN;
      end
      S_RUN: begin
        w_run = 1'b1;
        if (w_done || w_tmo) w_next_state = S_SWAP;
      end
      S_SWAP: begin
        w_swap       = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_armed   <= 1'b0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
      r_overrun <= '0;
    end else begin
      if (bus.vblank && (r_state != S_IDLE) && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
      if (r_state == S_KICK) begin
        r_armed   <= 1'b0;
        r_timeout <= 1'b0;
        r_cnt     <= '0;
      end else if (r_state == S_RUN) begin
        r_cnt <= w_cnt_inc;
        if (!bus.vg_halt) r_armed <= 1'b1;
        if (w_tmo && !w_done) r_timeout <= 1'b1;
      end
    end
  end

  avg_line_slot #(.LINE_W(LINE_W)) u_slot (
    .clk     (clk),
    .rst_b   (rst_b),
    .i_load  (w_q_read),
    .i_data  (w_head),
    .i_ready (bus.ln_ready),
    .o_valid (w_valid),
    .o_data  (w_line),
    .o_free  (w_slot_free)
  );

  assign bus.vggo        = w_vggo;
  assign bus.frame_swap  = w_swap;
  assign bus.q_read      = w_q_read;
  assign bus.ln_valid    = w_valid;
  assign {bus.ln_startX, bus.ln_startY, bus.ln_endX, bus.ln_endY, bus.ln_color} = w_line;
  assign bus.timeout     = r_timeout;
  assign bus.overrun_cnt = r_overrun;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_avg_frame_sched.sv
// Randomized bench for avg_frame_sched against a frame-level reference model.
module tb_avg_frame_sched;
  import avg_pkg::*;

  localparam int TMO    = 50;
  localparam int LW     = 4 * AVG_COORD_W_DEF + AVG_COLOR_W_DEF;
  localparam int P_IDLE = 0;
  localparam int P_KICK = 1;
  localparam int P_RUN  = 2;
  localparam int P_SWAP = 3;

  logic clk = 1'b0;
  logic rst_b;
  avg_sched_state_e dbg_state;

  avg_frame_sched_if #(.COORD_W(AVG_COORD_W_DEF), .COLOR_W(AVG_COLOR_W_DEF)) bus ();

  avg_frame_sched #(
    .COORD_W (AVG_COORD_W_DEF),
    .COLOR_W (AVG_COLOR_W_DEF),
    .TIMEOUT (TMO)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: lines taken from the queue, in the order the drawer must see them
  logic [LW-1:0] src_q[$];
  logic [LW-1:0] exp_q[$];

  // reference model of the frame sequence
  int   m_phase;
  int   m_run;
  int   m_ovr;
  logic m_armed;
  logic m_tmo;
  logic m_zero;

  // environment: core, drawer and ready behaviour
  int   core_left;
  int   core_len;
  int   busy_left;
  int   busy_max;
  logic rdy_rand;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_qread();
    return (m_phase == P_RUN) && (src_q.size() != 0) && ((exp_q.size() == 0) || bus.ln_ready);
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_run   = 0;
    m_ovr   = 0;
    m_armed = 1'b0;
    m_tmo   = 1'b0;
    m_zero  = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_lines(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(LW'({$urandom, $urandom}));
  endtask

  task automatic drive_env();
    avg_line_t     h;
    logic [LW-1:0] raw;
    bus.vg_halt   = (core_left == 0);
    bus.draw_busy = (busy_left != 0);
    bus.q_empty   = (src_q.size() == 0);
    if (rdy_rand) bus.ln_ready = ($urandom_range(0, 3) != 0);
    raw = (src_q.size() != 0) ? src_q[0] : LW'({$urandom, $urandom});
    h = raw;
    bus.q_startX = h.startX;
    bus.q_startY = h.startY;
    bus.q_endX   = h.endX;
    bus.q_endY   = h.endY;
    bus.q_color  = h.color;
  endtask

  task automatic check_outputs();
    logic [LW-1:0] got_line;
    int            ovr_sat;
    got_line = {bus.ln_startX, bus.ln_startY, bus.ln_endX, bus.ln_endY, bus.ln_color};
    ovr_sat  = (m_ovr > 255) ? 255 : m_ovr;
    chk("vggo", 64'(bus.vggo), 64'(m_phase == P_KICK));
    chk("frame_swap", 64'(bus.frame_swap), 64'(m_phase == P_SWAP));
    chk("q_read", 64'(bus.q_read), 64'(exp_qread()));
    chk("ln_valid", 64'(bus.ln_valid), 64'(exp_q.size() != 0));
    chk("timeout", 64'(bus.timeout), 64'(m_tmo));
    chk("overrun_cnt", 64'(bus.overrun_cnt), 64'(ovr_sat));
    if (exp_q.size() != 0) chk("ln_line", 64'(got_line), 64'(exp_q[0]));
    else if (m_zero) chk("ln_reset", 64'(got_line), 64'(0));
  endtask

  task automatic model_step();
    logic pop;
    logic acc;
    logic done;
    logic forced;
    if (core_left > 0) core_left--;
    if (busy_left > 0) busy_left--;
    if (!rst_b) begin
      model_reset();
      return;
    end
    pop  = exp_qread();
    acc  = (exp_q.size() != 0) && bus.ln_ready;
    done = m_armed && bus.vg_halt && (src_q.size() == 0) && (exp_q.size() == 0) && !bus.draw_busy;
    if (bus.vblank && (m_phase != P_IDLE)) m_ovr++;
    case (m_phase)
      P_IDLE: if (bus.vblank) m_phase = P_KICK;
      P_KICK: begin
        m_tmo     = 1'b0;
        m_run     = 0;
        m_armed   = 1'b0;
        m_phase   = P_RUN;
        core_left = core_len;
      end
      P_RUN: begin
        m_run++;
        forced = (m_run >= TMO);
        if (!bus.vg_halt) m_armed = 1'b1;
        if (done || forced) m_phase = P_SWAP;
        if (forced && !done) m_tmo = 1'b1;
      end
      default: m_phase = P_IDLE;
    endcase
    if (acc) begin
      void'(exp_q.pop_front());
      busy_left = $urandom_range(0, busy_max);
    end
    if (pop) begin
      exp_q.push_back(src_q.pop_front());
      m_zero = 1'b0;
    end
  endtask

  // driver: one clock cycle of stimulus, check and model update
  task automatic tick();
    drive_env();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
    bus.vblank = 1'b0;
  endtask

  initial begin
    rst_b         = 1'b0;
    bus.vblank    = 1'b0;
    bus.vg_halt   = 1'b1;
    bus.q_empty   = 1'b1;
    bus.q_startX  = '0;
    bus.q_startY  = '0;
    bus.q_endX    = '0;
    bus.q_endY    = '0;
    bus.q_color   = '0;
    bus.ln_ready  = 1'b1;
    bus.draw_busy = 1'b0;
    core_left = 0;
    core_len  = 20;
    busy_left = 0;
    busy_max  = 0;
    rdy_rand  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    repeat (3) tick();

    // basic frame: core runs 20 cycles, three lines arrive while it runs
    busy_max = 3;
    bus.vblank = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (i == 4 || i == 9 || i == 14) push_lines(1);
      tick();
    end

    // drawer stalls with two lines queued
    busy_max = 0;
    push_lines(2);
    bus.ln_ready = 1'b0;
    bus.vblank = 1'b1;
    tick();
    repeat (12) tick();
    bus.ln_ready = 1'b1;
    repeat (30) tick();

    // stale halt through KICK and early RUN
    core_len = 0;
    bus.vblank = 1'b1;
    tick();
    repeat (10) tick();
    core_left = 6;
    repeat (20) tick();

    // core never halts: forced end, then a normal frame clears timeout
    core_len = 200;
    bus.vblank = 1'b1;
    tick();
    repeat (60) tick();
    core_len = 5;
    bus.vblank = 1'b1;
    tick();
    repeat (15) tick();

    // vblank every cycle while frames are busy
    core_len = 1000;
    for (int i = 0; i < 400; i++) begin
      bus.vblank = 1'b1;
      tick();
    end
    repeat (60) tick();

    // random frames
    rdy_rand = 1'b1;
    busy_max = 2;
    for (int f = 0; f < 6; f++) begin
      push_lines($urandom_range(0, 4));
      core_len = $urandom_range(3, 40);
      bus.vblank = 1'b1;
      tick();
      for (int i = 0; i < 70; i++) begin
        if ($urandom_range(0, 7) == 0) push_lines(1);
        tick();
      end
    end
    rdy_rand = 1'b0;

    // reset in RUN while a line is held
    busy_max = 0;
    bus.ln_ready = 1'b0;
    push_lines(3);
    core_len = 30;
    bus.vblank = 1'b1;
    tick();
    repeat (5) tick();
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    repeat (3) tick();
    bus.ln_ready = 1'b1;
    core_len = 5;
    bus.vblank = 1'b1;
    tick();
    repeat (25) tick();

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/avg_frame_sched.md
# avg_frame_sched

Frame-level controller for the vector-generator path. On each vertical blank it kicks `avg_core` with a one-cycle `vggo`, drains decoded lines from `lineRegQueue` into the downstream line-drawing engine over a valid/ready handshake, and detects end of frame (core halted, queue empty, drawer idle). At frame end it issues a buffer-swap pulse. Sits between `avg_core`/`lineRegQueue` and the rasterizer, replacing the free-running fixed-interval `read` strobe.

## Interface
Parameters:
- `COORD_W`, 11, width of each X/Y coordinate
- `COLOR_W`, 3, width of the color field
- `TIMEOUT`, 100000, maximum cycles spent in RUN before a frame is forced to end

Ports:
- `clk`  in  1  single clock (the `clk_10x` domain)
- `rst_b`  in  1  synchronous, active-low reset
- `vblank`  in  1  one-cycle pulse at start of vertical blank
- `vg_halt`  in  1  level; high while `avg_core` is halted
- `vggo`  out  1  one-cycle start pulse to `avg_core`
- `q_empty`  in  1  queue empty flag
- `q_startX`, `q_startY`, `q_endX`, `q_endY`  in  COORD_W each  queue head line
- `q_color`  in  COLOR_W  queue head color
- `q_read`  out  1  pop queue head at this clock edge
- `ln_startX`, `ln_startY`, `ln_endX`, `ln_endY`  out  COORD_W each  line to drawer
- `ln_color`  out  COLOR_W  line color
- `ln_valid`  out  1  output line is valid
- `ln_ready`  in  1  drawer accepts the line when `ln_valid & ln_ready`
- `draw_busy`  in  1  drawer is still rendering an accepted line
- `frame_swap`  out  1  one-cycle pulse: frame complete, swap buffers
- `timeout`  out  1  sticky; set when a frame is force-ended, cleared by the next `vggo`
- `overrun_cnt`  out  8  count of `vblank` pulses dropped while busy; saturates at 255

## Operation
- States: IDLE, KICK, RUN, SWAP.
  - IDLE: a `vblank` pulse moves to KICK.
  - KICK: assert `vggo` for exactly one cycle, clear `timeout`, clear the cycle counter, clear `armed`; go to RUN.
  - RUN: `armed` sets on the first cycle `vg_halt == 0`. Go to SWAP when `armed & vg_halt & q_empty & !ln_valid & !draw_busy`, or when the cycle counter reaches `TIMEOUT` (set `timeout`).
  - SWAP: assert `frame_swap` for one cycle; go to IDLE.
- Stale-halt protection: `vg_halt` is ignored until `armed` is set. A stale halt left over from the previous frame never ends a frame.
- Queue semantics: head data is valid while `!q_empty` and is popped on the edge where `q_read == 1`.
- `q_read = !q_empty & (state == RUN) & (!ln_valid | ln_ready)`. On that edge the head is latched into the output slot and `ln_valid` is set.
- `ln_valid` clears on accept when no new pop occurs in the same cycle. Output fields stay stable while `ln_valid & !ln_ready`.
- A `vblank` pulse in any state other than IDLE is dropped and increments `overrun_cnt` (saturating).
- On TIMEOUT, lines still in the queue or the output slot are not flushed. `ln_valid` holds across SWAP/IDLE until accepted. The next RUN continues draining.

## Timing
- Reset (`rst_b` low at a clock edge) puts the block in IDLE. Reset values: `vggo=0`, `q_read=0`, `ln_valid=0`, all `ln_*` fields 0, `frame_swap=0`, `timeout=0`, `overrun_cnt=0`, `armed=0`, counter 0.
- Reset mid-frame aborts immediately; any held line is discarded.
- `vblank` sampled at edge N → `vggo` high in cycle N+1 → state RUN in cycle N+2.
- Pop latency: `q_read` high in cycle N → `ln_valid` and data present in cycle N+1.
- Throughput: one line per cycle when `ln_ready` is held high.
- End-of-frame condition true in cycle N → `frame_swap` high in cycle N+1.
- Cycle counter increments every RUN cycle. Width is `$clog2(TIMEOUT+1)`. It never wraps because it is compared with `>=`.
- Simultaneous `vblank` and SWAP: the pulse counts as an overrun.

## Structure
- Package `avg_pkg`:
  - `avg_sched_state_e` enum.
  - `avg_line_t` packed struct {startX, startY, endX, endY, color}, sized by COORD_W/COLOR_W defaults.
  - `AVG_TIMEOUT_DEF` constant.
- Sub-module `avg_line_slot`: one-entry output register with valid/ready and load/accept logic. The FSM, the counters and `armed` live in the top module.

## Test plan
- Reset, then one `vblank`; core model drops halt for 20 cycles and queue supplies 3 lines; `ln_ready=1` → `vggo` is one cycle; the 3 lines appear in order; `frame_swap` is one cycle after the drawer goes idle; `timeout=0`.
- `ln_ready` held low 10 cycles with 2 lines queued → `ln_valid` and data stay stable; `q_read` stays 0 until `ln_ready` rises.
- `vg_halt` held high through KICK and the first RUN cycles, then dropped → no `frame_swap` before `armed` is set.
- `TIMEOUT=50`, core never halts → `frame_swap` at RUN cycle 50; `timeout=1`; the next `vggo` clears it.
- 300 `vblank` pulses during RUN → `overrun_cnt=255`.
- `rst_b` low mid-RUN with `ln_valid=1` → the next cycle is IDLE with all outputs at reset values.
